// File: rtl/i2c_target_regfile_if.sv
// I2C pin bundle for the register-file target.
//   scl_i    : I2C clock pin value (asynchronous to clk_i)
//   sda_i    : I2C data pin value (asynchronous to clk_i)
//   sda_oe_o : 1 = target pulls SDA low, 0 = release (open-drain pad lives outside)
// Modports: master drives the pins and observes the pull-down; slave is the target.
interface i2c_target_regfile_if;
  logic scl_i;
  logic sda_i;
  logic sda_oe_o;

  modport master (output scl_i, output sda_i, input sda_oe_o);
  modport slave  (input scl_i, input sda_i, output sda_oe_o);
endinterface

// File: rtl/i2c_target_regfile.sv
// I2C target exposing a bank of 8-bit registers.
// A write sets the register pointer with its first data byte; later bytes are
// written at the pointer with auto-increment. A read streams regs[pointer]
// onwards. Pointer survives STOP/START, so write-pointer-then-read works.
// Ports:
//   clk_i              system clock, at least 16x SCL
//   rst_ni             asynchronous active-low reset
//   assigned_address_i 7-bit target address
//   bus                I2C pins (scl_i, sda_i in; sda_oe_o out)
//   regs_o             register n at bits [8n+7:8n]
//   wr_stb_o/wr_addr_o one-cycle pulse + index when the bus writes a register
//   rd_stb_o           one-cycle pulse when a register is loaded for transmit
//   busy_o             high from address match until STOP
//   dbg_state_o        current FSM state
module i2c_target_regfile #(
  parameter int          REGISTERS     = 16,
  parameter int          SYNC_STAGES   = 2,
  parameter logic [7:0]  RESET_ADDRESS = 8'h00
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [6:0]             assigned_address_i,
  i2c_target_regfile_if.slave    bus,
  output logic [8*REGISTERS-1:0] regs_o,
  output logic                   wr_stb_o,
  output logic [7:0]             wr_addr_o,
  output logic                   rd_stb_o,
  output logic                   busy_o,
  output logic [3:0]             dbg_state_o
);

  localparam int         IDXW     = (REGISTERS > 1) ? $clog2(REGISTERS) : 1;
  localparam logic [7:0] LAST_PTR = 8'(REGISTERS - 1);
  localparam logic [8:0] NUM_REGS = 9'(REGISTERS);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    PTR       = 4'd3,
    PTR_ACK   = 4'd4,
    WDATA     = 4'd5,
    WDATA_ACK = 4'd6,
    RDATA     = 4'd7,
    RDATA_ACK = 4'd8,
    IGNORE    = 4'd9
  } state_t;

  state_t               state;
  logic [7:0]           regs [REGISTERS];
  logic [7:0]           pointer;
  logic [7:0]           shifter;
  logic [2:0]           bit_cnt;
  logic                 rw;
  logic                 ack;
  logic                 sda_oe;

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;

  // Synchronisers idle at 1 (bus released) so reset exit never fakes an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_i};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  logic       scl_s, sda_s;
  logic       start_det, stop_det, scl_rise, scl_fall;
  logic [7:0] rx_byte, ptr_next, rd_cur, rd_next;
  logic       ptr_ok, next_ok;

  always_comb begin
    scl_s     = scl_sync[SYNC_STAGES-1];
    sda_s     = sda_sync[SYNC_STAGES-1];
    start_det = scl_s & scl_d & sda_d & ~sda_s;
    stop_det  = scl_s & scl_d & ~sda_d & sda_s;
    scl_rise  = scl_s & ~scl_d;
    scl_fall  = ~scl_s & scl_d;
    rx_byte   = {shifter[6:0], sda_s};
    ptr_next  = (pointer == LAST_PTR) ? 8'h00 : pointer + 8'h01;
    ptr_ok    = {1'b0, pointer}  < NUM_REGS;
    next_ok   = {1'b0, ptr_next} < NUM_REGS;
    // Out-of-range pointers read back as zero.
    rd_cur    = ptr_ok  ? regs[pointer[IDXW-1:0]]  : 8'h00;
    rd_next   = next_ok ? regs[ptr_next[IDXW-1:0]] : 8'h00;
  end

  // Decisions are made on SCL rising edges; SDA is only changed on falling
  // edges, based on the state reached at the preceding rise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      pointer   <= RESET_ADDRESS;
      shifter   <= 8'h00;
      bit_cnt   <= 3'd0;
      rw        <= 1'b0;
      ack       <= 1'b0;
      sda_oe    <= 1'b0;
      wr_stb_o  <= 1'b0;
      wr_addr_o <= 8'h00;
      rd_stb_o  <= 1'b0;
      busy_o    <= 1'b0;
      for (int i = 0; i < REGISTERS; i++) regs[i] <= 8'h00;
    end else begin
      wr_stb_o <= 1'b0;
      rd_stb_o <= 1'b0;
      if (start_det) begin
        state   <= ADDR;
        bit_cnt <= 3'd0;
        sda_oe  <= 1'b0;
      end else if (stop_det) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy_o <= 1'b0;
      end else if (scl_rise) begin
        case (state)
          ADDR: begin
            shifter <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rw <= sda_s;
              // shifter[6:0] already holds the seven address bits.
              if (shifter[6:0] == assigned_address_i) begin
                state  <= ADDR_ACK;
                busy_o <= 1'b1;
              end else begin
                state <= IGNORE;
              end
            end
          end
          ADDR_ACK: begin
            bit_cnt <= 3'd0;
            if (rw) begin
              state    <= RDATA;
              shifter  <= rd_cur;
              rd_stb_o <= 1'b1;
            end else begin
              state <= PTR;
            end
          end
          PTR: begin
            shifter <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              pointer <= rx_byte;
              state   <= PTR_ACK;
            end
          end
          PTR_ACK: begin
            bit_cnt <= 3'd0;
            state   <= WDATA;
          end
          WDATA: begin
            shifter <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= WDATA_ACK;
              if (ptr_ok) begin
                regs[pointer[IDXW-1:0]] <= rx_byte;
                wr_stb_o  <= 1'b1;
                wr_addr_o <= pointer;
                ack       <= 1'b1;
              end else begin
                ack <= 1'b0;
              end
            end
          end
          WDATA_ACK: begin
            pointer <= ptr_next;
            bit_cnt <= 3'd0;
            state   <= WDATA;
          end
          RDATA: begin
            shifter <= {shifter[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= RDATA_ACK;
          end
          RDATA_ACK: begin
            bit_cnt <= 3'd0;
            if (!sda_s) begin
              pointer  <= ptr_next;
              shifter  <= rd_next;
              rd_stb_o <= 1'b1;
              state    <= RDATA;
            end else begin
              state <= IGNORE;
            end
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state)
          ADDR_ACK, PTR_ACK: sda_oe <= 1'b1;
          WDATA_ACK:         sda_oe <= ack;
          RDATA:             sda_oe <= ~shifter[7];
          default:           sda_oe <= 1'b0;
        endcase
      end
    end
  end

  assign bus.sda_oe_o = sda_oe;
  assign dbg_state_o  = state;

  for (genvar g = 0; g < REGISTERS; g++) begin : g_regs
    assign regs_o[8*g +: 8] = regs[g];
  end

endmodule
